// File: rtl/pfb_mac_pkg.sv
// Shared types and constants for the PFB multichannel MAC.
package pfb_mac_pkg;

  // Ceiling log2, never smaller than 1 so that it can size index fields.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_DIN0_WIDTH = 16;
  localparam int DEF_DIN1_WIDTH = 16;
  localparam int DEF_NUM_CHAN   = 8;

  localparam int PROD_WIDTH = DEF_DIN0_WIDTH + DEF_DIN1_WIDTH;
  localparam int CHAN_W     = clog2(DEF_NUM_CHAN);

  // Channel field is wide enough for any practical channel count; users slice it.
  localparam int TAG_CHAN_W = 16;

  typedef struct packed {
    logic [TAG_CHAN_W-1:0] chan;
    logic                  first;
    logic                  last;
  } tag_t;

endpackage

// File: rtl/pfb_mac_if.sv
// Streaming handshake bundle for the PFB multichannel MAC.
interface pfb_mac_if #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 18,
  parameter int OUT_CHAN_W = pfb_mac_pkg::CHAN_W
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic [OUT_CHAN_W-1:0]        out_chan;
  logic                         sat_flag;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, out_chan, sat_flag
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, out_chan, sat_flag
  );
endinterface

// File: rtl/pfb_mac_mul_pipe.sv
// Signed multiplier with STAGES registers, clock enable and tag passthrough.
module pfb_mac_mul_pipe
  import pfb_mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            vld_in,
  input  logic signed [DATA_W-1:0]        a,
  input  logic signed [COEF_W-1:0]        b,
  input  tag_t                            tag_in,
  output logic                            vld_out,
  output logic signed [DATA_W+COEF_W-1:0] prod,
  output tag_t                            tag_out
);
  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0] prod_p [STAGES];
  tag_t                 tag_p  [STAGES];
  logic                 vld_p  [STAGES];

  // Valid bits shift with the data and are the only reset state here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
    end else if (en) begin
      vld_p[0] <= vld_in;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Product is formed at the first register; later stages just retime it.
  always_ff @(posedge clk) begin
    if (en) begin
      prod_p[0] <= PW'(a) * PW'(b);
      tag_p[0]  <= tag_in;
      for (int i = 1; i < STAGES; i++) begin
        prod_p[i] <= prod_p[i-1];
        tag_p[i]  <= tag_p[i-1];
      end
    end
  end

  assign vld_out = vld_p[STAGES-1];
  assign prod    = prod_p[STAGES-1];
  assign tag_out = tag_p[STAGES-1];

endmodule

// File: rtl/pfb_multichannel_mac.sv
// Pipelined per-channel multiply-accumulate for the PFB decimator.
// Define PFB_MAC_SAT_EN to clamp results and drive the sticky sat_flag;
// otherwise results wrap to DOUT_WIDTH and sat_flag is tied low.
module pfb_multichannel_mac
  import pfb_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int NUM_STAGE  = 2,
  parameter int NUM_CHAN   = 8,
  parameter int NUM_TAPS   = 4,
  parameter int ACC_WIDTH  = 36,
  parameter int OUT_SHIFT  = 15,
  parameter int DOUT_WIDTH = 18
) (
  input  logic     ap_clk,
  input  logic     ap_rst,
  pfb_mac_if.slave bus
);
  localparam int PROD_W    = DIN0_WIDTH + DIN1_WIDTH;
  localparam int CHAN_BITS = clog2(NUM_CHAN);
  localparam int TAP_BITS  = clog2(NUM_TAPS);
  localparam int RW        = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] HALF =
    (OUT_SHIFT == 0) ? '0 : (RW'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0));

  // Round half up; one guard bit keeps the +HALF from overflowing.
  function automatic logic signed [RW-1:0] round_half_up(input logic signed [ACC_WIDTH-1:0] s);
    logic signed [RW-1:0] t;
    t = RW'(s) + HALF;
    return t >>> OUT_SHIFT;
  endfunction

`ifdef PFB_MAC_SAT_EN
  localparam logic signed [RW-1:0] DMAX = RW'((longint'(1) <<< (DOUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] DMIN = ~DMAX;

  function automatic logic sat_hit(input logic signed [RW-1:0] r);
    return (r > DMAX) || (r < DMIN);
  endfunction

  function automatic logic signed [DOUT_WIDTH-1:0] fit(input logic signed [RW-1:0] r);
    if (r > DMAX) return DMAX[DOUT_WIDTH-1:0];
    if (r < DMIN) return DMIN[DOUT_WIDTH-1:0];
    return r[DOUT_WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [DOUT_WIDTH-1:0] fit(input logic signed [RW-1:0] r);
    return r[DOUT_WIDTH-1:0];
  endfunction
`endif

  logic                  enable;
  logic                  accept;
  logic [CHAN_BITS-1:0]  chan_cnt;
  logic [TAP_BITS-1:0]   tap_cnt;
  tag_t                  tag_in;

  // Backpressure depends only on the output register, never on in_valid.
  assign enable       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = enable;
  assign accept       = bus.in_valid && enable;

  // Tap-major input position: channel advances every accept, tap on channel wrap.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      chan_cnt <= '0;
      tap_cnt  <= '0;
    end else if (accept) begin
      if (chan_cnt == CHAN_BITS'(NUM_CHAN - 1)) begin
        chan_cnt <= '0;
        if (tap_cnt == TAP_BITS'(NUM_TAPS - 1)) tap_cnt <= '0;
        else                                    tap_cnt <= tap_cnt + 1'b1;
      end else begin
        chan_cnt <= chan_cnt + 1'b1;
      end
    end
  end

  // Tag each accepted pair with its channel and frame position.
  always_comb begin
    tag_in       = '0;
    tag_in.chan  = TAG_CHAN_W'(chan_cnt);
    tag_in.first = (tap_cnt == '0);
    tag_in.last  = (tap_cnt == TAP_BITS'(NUM_TAPS - 1));
  end

  logic                     m_vld;
  logic signed [PROD_W-1:0] m_prod;
  tag_t                     m_tag;

  pfb_mac_mul_pipe #(
    .DATA_W (DIN0_WIDTH),
    .COEF_W (DIN1_WIDTH),
    .STAGES (NUM_STAGE)
  ) u_mul (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .en      (enable),
    .vld_in  (accept),
    .a       (bus.din0),
    .b       (bus.din1),
    .tag_in  (tag_in),
    .vld_out (m_vld),
    .prod    (m_prod),
    .tag_out (m_tag)
  );

  // ---- accumulate stage (p1) ----
  logic signed [ACC_WIDTH-1:0] acc [NUM_CHAN];
  logic [TAG_CHAN_W-1:0]       unused_chan;
  logic [CHAN_BITS-1:0]        m_chan;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] sum_p1;
  logic [CHAN_BITS-1:0]        chan_p1;
  logic                        vld_p1;

  assign unused_chan = m_tag.chan;
  assign m_chan      = m_tag.chan[CHAN_BITS-1:0];
  assign prod_ext    = ACC_WIDTH'(m_prod);
  assign sum         = m_tag.first ? prod_ext : acc[m_chan] + prod_ext;

  // Accumulator bank is never reset: the first tap overwrites stale contents.
  always_ff @(posedge ap_clk) begin
    if (enable && m_vld) acc[m_chan] <= sum;
  end

  // Only last-tap sums become results.
  always_ff @(posedge ap_clk) begin
    if (ap_rst)      vld_p1 <= 1'b0;
    else if (enable) vld_p1 <= m_vld && m_tag.last;
  end

  // Result sum is captured straight from the adder, not from the stored acc.
  always_ff @(posedge ap_clk) begin
    if (enable) begin
      sum_p1  <= sum;
      chan_p1 <= m_chan;
    end
  end

  // ---- round / width-reduce / output register (p2) ----
  logic signed [DOUT_WIDTH-1:0] dout_nxt;
  assign dout_nxt = fit(round_half_up(sum_p1));

  // Output register holds until taken; a take with no new result clears valid.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      bus.out_valid <= 1'b0;
      bus.dout      <= '0;
      bus.out_chan  <= '0;
    end else if (enable) begin
      bus.out_valid <= vld_p1;
      if (vld_p1) begin
        bus.dout     <= dout_nxt;
        bus.out_chan <= chan_p1;
      end
    end
  end

`ifdef PFB_MAC_SAT_EN
  logic sat_q;

  // Sticky clamp indicator, cleared only by reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst)                                                  sat_q <= 1'b0;
    else if (enable && vld_p1 && sat_hit(round_half_up(sum_p1))) sat_q <= 1'b1;
  end

  assign bus.sat_flag = sat_q;
`else
  assign bus.sat_flag = 1'b0;
`endif

endmodule
